// File: rtl/gpio_int_ack_pkg.sv
// Shared types and constants for the GPIO interrupt acknowledge engine.
package gpio_int_ack_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    ACK    = 2'd2,
    SETTLE = 2'd3
  } fsmState_t;

  localparam int NUM_BITS  = 16;
  localparam int BIT_IDX_W = 4;

  // GPIO register map
  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_DIR  = 3'd1;
  localparam logic [2:0] ADDR_EDGE = 3'd2;
  localparam logic [2:0] ADDR_FILT = 3'd3;

endpackage

// File: rtl/gpio_evt_fifo.sv
// Small synchronous event FIFO; head data holds the last popped entry while empty.
module gpio_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Push,
  input  logic [WIDTH-1:0]         PushData,
  input  logic                     Pop,
  output logic [WIDTH-1:0]         PopData,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr, headPtr;
  logic             doPush, doPop;

  assign Full   = (Count == CW'(DEPTH));
  assign Empty  = (Count == '0);
  assign doPop  = Pop && !Empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign doPush = Push && (!Full || doPop);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      Count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   Count <= Count + CW'(1);
        2'b01:   Count <= Count - CW'(1);
        default: Count <= Count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (doPush) mem[wrPtr] <= PushData;
  end

  assign headPtr = Empty ? rdPtr - AW'(1) : rdPtr;
  assign PopData = mem[headPtr];

endmodule

// File: rtl/gpio_int_ack.sv
// Services pending GPIO interrupts lowest-bit first: read port, strobe clear, queue a timestamped event.
module gpio_int_ack
  import gpio_int_ack_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TS_WIDTH   = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [15:0]          IntStatus,
  output logic [15:0]          IntReset,
  input  logic [15:0]          IrqMask,
  output logic [2:0]           BusAddr,
  output logic                 BusEn,
  output logic                 BusRd,
  input  logic [15:0]          BusDataRd,
  output logic                 EvtValid,
  input  logic                 EvtReady,
  output logic [3:0]           EvtBit,
  output logic [15:0]          EvtPort,
  output logic [TS_WIDTH-1:0]  EvtTime,
  output logic                 Overflow,
  input  logic                 OverflowClr
);

  typedef struct packed {
    logic [BIT_IDX_W-1:0] bitIdx;
    logic [NUM_BITS-1:0]  port;
    logic [TS_WIDTH-1:0]  ts;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fsmState_t            state, stateNxt;
  logic [NUM_BITS-1:0]  pend, pendLow, sel;
  logic [BIT_IDX_W-1:0] selIdx;
  logic [NUM_BITS-1:0]  snapPort;
  logic [TS_WIDTH-1:0]  snapTs, tsCnt;
  logic                 push, popFire, fifoFull, fifoEmpty;
  logic [CNT_W-1:0]     fifoCount;
  evt_t                 pushEvt, headEvt;

  // Isolate the lowest pending bit: x & -x.
  assign pend    = IntStatus & IrqMask;
  assign pendLow = pend & (~pend + 16'd1);

  always_comb begin
    selIdx = '0;
    for (int i = 0; i < NUM_BITS; i++)
      if (sel[i]) selIdx = selIdx | BIT_IDX_W'(i);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      sel   <= '0;
      tsCnt <= '0;
    end else begin
      state <= stateNxt;
      tsCnt <= tsCnt + TS_WIDTH'(1);
      if (state == IDLE && pend != '0) sel <= pendLow;
    end
  end

  // Snapshot registers carry no reset; they are always written before use.
  always_ff @(posedge Clk) begin
    if (state == READ) begin
      snapPort <= BusDataRd;
      snapTs   <= tsCnt;
    end
  end

  always_comb begin
    stateNxt = state;
    BusEn    = 1'b0;
    BusRd    = 1'b0;
    BusAddr  = ADDR_DATA;
    IntReset = '0;
    push     = 1'b0;
    case (state)
      IDLE:   if (pend != '0) stateNxt = READ;
      READ: begin
        BusEn    = 1'b1;
        BusRd    = 1'b1;
        BusAddr  = ADDR_DATA;
        stateNxt = ACK;
      end
      ACK: begin
        IntReset = sel;
        push     = 1'b1;
        stateNxt = SETTLE;
      end
      SETTLE: stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  assign popFire = EvtReady && !fifoEmpty;

  // Set beats clear so a drop coinciding with OverflowClr is never lost.
  always_ff @(posedge Clk) begin
    if (Reset)                            Overflow <= 1'b0;
    else if (push && fifoFull && !popFire) Overflow <= 1'b1;
    else if (OverflowClr)                 Overflow <= 1'b0;
  end

  assign pushEvt = '{bitIdx: selIdx, port: snapPort, ts: snapTs};

  gpio_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) uFifo (
    .Clk      (Clk),
    .Reset    (Reset),
    .Push     (push),
    .PushData (pushEvt),
    .Pop      (EvtReady),
    .PopData  (headEvt),
    .Full     (fifoFull),
    .Empty    (fifoEmpty),
    .Count    (fifoCount)
  );

  assign EvtValid = !fifoEmpty;
  assign EvtBit   = headEvt.bitIdx;
  assign EvtPort  = headEvt.port;
  assign EvtTime  = headEvt.ts;

  assert property (@(posedge Clk) disable iff (Reset) fifoCount <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_gpio_int_ack.sv
// Bench for gpio_int_ack: vector table plus hand sequences, scoreboarded event stream.
module tb_gpio_int_ack;

  logic        Clk = 1'b0, Reset = 1'b1;
  logic [15:0] IntStatus, IntReset, IrqMask = 16'hFFFF, BusDataRd = 16'h0;
  logic [2:0]  BusAddr;
  logic        BusEn, BusRd, EvtValid, EvtReady = 1'b0, Overflow, OverflowClr = 1'b0;
  logic [3:0]  EvtBit;
  logic [15:0] EvtPort, EvtTime;

  gpio_int_ack #(.FIFO_DEPTH(4), .TS_WIDTH(16)) dut (
    .Clk(Clk), .Reset(Reset), .IntStatus(IntStatus), .IntReset(IntReset),
    .IrqMask(IrqMask), .BusAddr(BusAddr), .BusEn(BusEn), .BusRd(BusRd),
    .BusDataRd(BusDataRd), .EvtValid(EvtValid), .EvtReady(EvtReady),
    .EvtBit(EvtBit), .EvtPort(EvtPort), .EvtTime(EvtTime),
    .Overflow(Overflow), .OverflowClr(OverflowClr)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [15:0] st, mask, port; int nExp; logic [15:0] rem; } vec_t;
  typedef struct { logic [3:0] b; logic [15:0] port; } exp_t;

  exp_t        expQ[$];
  logic [15:0] tsQ[$];
  exp_t        monE;
  vec_t        vt[5];
  int          tests = 0, fails = 0, strobes = 0, cyc = 0;
  int          vecId = -1, lastVec = -2, lastPop = 0;
  logic [15:0] status = '0, raise = '0, tsM = '0;
  logic        clrAll = 1'b0;

  // Sticky GPIO status model, cleared bitwise by the strobe
  assign IntStatus = status;
  always @(posedge Clk) status <= clrAll ? 16'h0 : ((status & ~IntReset) | raise);

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    tsM <= Reset ? 16'h0 : tsM + 16'd1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: timestamps expected at each READ, events checked at each pop
  always @(negedge Clk) begin
    if (IntReset != 16'h0) strobes++;
    if (BusEn) tsQ.push_back(tsM);
    if (EvtValid && EvtReady && !Reset) begin
      if (expQ.size() == 0) chk("unexpected event", 1, 0);
      else begin
        monE = expQ.pop_front();
        chk("evt bit", EvtBit, monE.b);
        chk("evt port", EvtPort, monE.port);
        chk("evt ts present", tsQ.size() != 0, 1);
        if (tsQ.size() != 0) chk("evt time", EvtTime, tsQ.pop_front());
        if (vecId >= 0 && vecId == lastVec) chk("evt spacing", cyc - lastPop, 4);
        lastVec = vecId;
        lastPop = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (expQ.size() != 0 && k < budget) begin tick(); k++; end
    chk("drain done", expQ.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] p;
    int s0;
    bit found;
    vt[0] = '{16'h0010, 16'hFFFF, 16'hA5A5, 1, 16'h0000};
    vt[1] = '{16'h8005, 16'hFFFF, 16'h1234, 3, 16'h0000};
    vt[2] = '{16'h0003, 16'h0002, 16'h0F0F, 1, 16'h0001};
    vt[3] = '{16'hFFFF, 16'h8001, 16'h5555, 2, 16'h7FFE};
    vt[4] = '{16'h0000, 16'hFFFF, 16'hBEEF, 0, 16'h0000};

    repeat (3) tick();
    chk("rst EvtValid", EvtValid, 0);
    chk("rst Overflow", Overflow, 0);
    chk("rst IntReset", IntReset, 0);
    chk("rst BusEn", BusEn, 0);
    chk("rst BusRd", BusRd, 0);
    chk("rst BusAddr", BusAddr, 0);
    Reset = 1'b0;
    tick();

    // Single event latency
    BusDataRd = 16'hA5A5;
    expQ.push_back('{4'd4, 16'hA5A5});
    raise = 16'h0010;
    tick(); raise = '0;
    chk("lat N BusEn", BusEn, 0);
    tick();
    chk("lat N+1 BusEn", BusEn, 1);
    chk("lat N+1 BusRd", BusRd, 1);
    chk("lat N+1 BusAddr", BusAddr, 0);
    chk("lat N+1 IntReset", IntReset, 0);
    tick();
    chk("lat N+2 IntReset", IntReset, 16'h0010);
    chk("lat N+2 BusEn", BusEn, 0);
    tick();
    chk("lat N+3 EvtValid", EvtValid, 1);
    chk("lat N+3 EvtBit", EvtBit, 4);
    chk("lat N+3 EvtPort", EvtPort, 16'hA5A5);
    chk("lat N+3 IntReset", IntReset, 0);
    EvtReady = 1'b1;
    tick(); EvtReady = 1'b0;
    chk("empty EvtValid", EvtValid, 0);
    chk("empty hold EvtBit", EvtBit, 4);
    repeat (2) tick();

    // Table vectors, consumer always ready
    for (int i = 0; i < 5; i++) begin
      vecId = i;
      IrqMask = vt[i].mask;
      BusDataRd = vt[i].port;
      EvtReady = 1'b1;
      s0 = strobes;
      p = vt[i].st & vt[i].mask;
      for (int b = 0; b < 16; b++) if (p[b]) expQ.push_back('{4'(b), vt[i].port});
      raise = vt[i].st;
      tick(); raise = '0;
      drain(200);
      repeat (8) tick();
      chk($sformatf("vec%0d remaining status", i), status, vt[i].rem);
      chk($sformatf("vec%0d strobe count", i), strobes - s0, vt[i].nExp);
      clrAll = 1'b1;
      tick(); clrAll = 1'b0;
      vecId = -1;
    end

    // Overflow: five events into a four-deep FIFO with no consumer
    IrqMask = 16'hFFFF;
    BusDataRd = 16'h5A5A;
    EvtReady = 1'b0;
    s0 = strobes;
    for (int b = 0; b < 4; b++) expQ.push_back('{4'(b), 16'h5A5A});
    raise = 16'h001F;
    tick(); raise = '0;
    repeat (24) tick();
    chk("ovf strobes", strobes - s0, 5);
    chk("ovf Overflow", Overflow, 1);
    chk("ovf EvtValid", EvtValid, 1);
    chk("ovf status", status, 0);
    chk("ovf ts count", tsQ.size(), 5);
    if (tsQ.size() != 0) void'(tsQ.pop_back());
    OverflowClr = 1'b1;
    tick(); OverflowClr = 1'b0;
    chk("ovf cleared", Overflow, 0);

    // Full FIFO with pop in the ACK cycle
    BusDataRd = 16'hC3C3;
    expQ.push_back('{4'd5, 16'hC3C3});
    raise = 16'h0020;
    tick(); raise = '0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (IntReset != 16'h0) found = 1;
      else tick();
    end
    chk("fullpop ACK seen", found, 1);
    EvtReady = 1'b1;
    tick(); EvtReady = 1'b0;
    repeat (4) tick();
    chk("fullpop Overflow", Overflow, 0);
    EvtReady = 1'b1;
    drain(50);
    chk("fullpop Overflow end", Overflow, 0);

    // Reset during READ abandons the sequence
    BusDataRd = 16'h7E7E;
    s0 = strobes;
    raise = 16'h0080;
    tick(); raise = '0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (BusEn) found = 1;
      else tick();
    end
    chk("rstseq READ seen", found, 1);
    Reset = 1'b1;
    tick();
    chk("rstseq IntReset", IntReset, 0);
    chk("rstseq EvtValid", EvtValid, 0);
    chk("rstseq BusEn", BusEn, 0);
    Reset = 1'b0;
    tsQ.delete();
    tick();
    chk("rstseq no strobe", IntReset, 0);
    chk("rstseq strobe count", strobes - s0, 0);
    chk("rstseq pending", status, 16'h0080);
    expQ.push_back('{4'd7, 16'h7E7E});
    drain(50);
    repeat (4) tick();
    chk("rstseq serviced", status, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
